alu_mdu_seq: RTL and testbench

- Parametrised multi-cycle multiply/divide unit for the MIPS core; companion to the single-cycle combinational ALU.
- Executes MULT/MULTU/DIV/DIVU iteratively (one bit per cycle) into architectural HI/LO registers, and services MTHI/MTLO writes.
- Sits in EX beside the ALU. The control unit stalls on busy and uses the done pulse to release MFHI/MFLO.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/mdu_sign_fix.sv | 47 ++++
 rtl/alu_mdu_seq.sv | 158 +++++++++++++++
 tb/tb_alu_mdu_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared decode definitions for the EX stage: multiply/divide opcodes, the
// MDU sequencer states and the combinational ALU operation codes.
//   mdu_op_e    : 3-bit op field driven into alu_mdu_seq.op
//   mdu_state_e : alu_mdu_seq FSM states
//   alu_op_e    : operation select of the single-cycle ALU
package alu_pkg;

    typedef enum logic [2:0] {
        OP_MULTU = 3'b000,
        OP_MULT  = 3'b001,
        OP_DIVU  = 3'b010,
        OP_DIV   = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } mdu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } mdu_state_e;

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluXor,
        AluNor,
        AluSlt,
        AluSltu,
        AluSll,
        AluSrl,
        AluSra,
        AluLui
    } alu_op_e;

    // MULT and DIV treat operands as two's complement; everything else is raw.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign helpers for the multiply/divide unit.
//   op, a, b         : raw request; produce magnitudes and sign flags at latch time
//   a_mag/b_mag      : |a|, |b| for signed ops, raw values otherwise
//   a_neg/b_neg      : operand sign (always 0 for unsigned ops)
//   acc              : finished magnitude accumulator {upper, lower}
//   neg_res/neg_rem  : negate product/quotient, negate remainder
//   divz             : divide by zero, quotient passes through untouched
//   prod_fix/quot_fix/rem_fix : signed results written into HI/LO
module mdu_sign_fix
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   a_mag,
    output logic [WIDTH-1:0]   b_mag,
    output logic               a_neg,
    output logic               b_neg,
    input  logic [2*WIDTH-1:0] acc,
    input  logic               neg_res,
    input  logic               neg_rem,
    input  logic               divz,
    output logic [2*WIDTH-1:0] prod_fix,
    output logic [WIDTH-1:0]   quot_fix,
    output logic [WIDTH-1:0]   rem_fix
);

    logic is_signed;

    always_comb begin
        is_signed = is_signed_op(op);
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        // |MIN| wraps to MIN, which is the correct unsigned magnitude.
        a_mag     = a_neg ? (~a + 1'b1) : a;
        b_mag     = b_neg ? (~b + 1'b1) : b;

        prod_fix  = neg_res ? (~acc + 1'b1) : acc;
        quot_fix  = (neg_res && !divz) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        // On divide by zero the remainder magnitude is |dividend|; restoring the
        // dividend's sign yields the raw dividend, as required for HI.
        rem_fix   = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

endmodule

// File: rtl/alu_mdu_seq.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One product/quotient bit per cycle; WIDTH+2 cycles from accepted start to done.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start, op    : request strobe and opcode (sampled only while idle)
//   srcA, srcB   : multiplicand/dividend/MTHI-MTLO data, multiplier/divisor
//   abort        : cancels the in-flight operation, HI/LO untouched
//   busy, done   : operation in flight, one-cycle result-valid pulse
//   hi, lo       : HI/LO registers; zero flags both clear
module alu_mdu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
    logic               is_div_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               divz_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               a_neg, b_neg;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] div_next;

    mdu_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .op       (op),
        .a        (srcA),
        .b        (srcB),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .a_neg    (a_neg),
        .b_neg    (b_neg),
        .acc      (acc_q),
        .neg_res  (neg_res_q),
        .neg_rem  (neg_rem_q),
        .divz     (divz_q),
        .prod_fix (prod_fix),
        .quot_fix (quot_fix),
        .rem_fix  (rem_fix)
    );

    always_comb begin
        // Shift-add: add multiplicand when the current multiplier LSB is set,
        // then shift the whole accumulator right keeping the carry.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring step. Two guard bits keep the borrow honest even for a zero
        // divisor, where the partial remainder is not bounded by the divisor.
        div_trial = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {2'b00, opnd_q};
        if (div_trial[WIDTH+1]) begin
            div_next = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        if (!op[2]) begin
                            is_div_q  <= op[1];
                            neg_res_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            divz_q    <= op[1] && (srcB == '0);
                            opnd_q    <= op[1] ? b_mag : a_mag;
                            acc_q     <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                            cnt_q     <= CNT_W'(WIDTH);
                            state_q   <= StRun;
                        end else if (op == OP_MTHI) begin
                            hi_q <= srcA;
                        end else if (op == OP_MTLO) begin
                            lo_q <= srcA;
                        end
                    end
                end
                StRun: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q <= is_div_q ? div_next : mul_next;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= StFix;
                        end
                    end
                end
                StFix: begin
                    state_q <= StIdle;
                    if (!abort) begin
                        done_q <= 1'b1;
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q == StRun) || (state_q == StFix);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign zero = (hi_q == '0) && (lo_q == '0);

endmodule

// File: tb/tb_alu_mdu_seq.sv
module tb_alu_mdu_seq;

    localparam logic [2:0] MULTU = 3'd0, MULT = 3'd1, DIVU = 3'd2, DIV = 3'd3;
    localparam logic [2:0] MTHI = 3'd4, MTLO = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] srcA = '0, srcB = '0;
    logic        busy, done, zero;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0;
    logic [2:0]  op8 = '0;
    logic [7:0]  srcA8 = '0, srcB8 = '0;
    logic        busy8, done8, zero8;
    logic [7:0]  hi8, lo8;

    int n_checks = 0;
    int n_pass = 0;
    logic [31:0] model_hi = '0, model_lo = '0;

    always #5 clk = ~clk;

    alu_mdu_seq #(.WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
        .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo), .zero(zero)
    );

    alu_mdu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .srcA(srcA8), .srcB(srcB8),
        .abort(1'b0), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .zero(zero8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Architectural result {hi, lo} computed with plain integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint unsigned ua, ub, up;
        longint          sa, sb, sp, q, rm;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            MULTU: begin up = ua * ub; return up; end
            MULT:  begin sp = sa * sb; return sp; end
            DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = longint'(ua / ub); rm = longint'(ua % ub);
                return {rm[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb; rm = sa % sb;
                return {rm[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Issue one operation; optionally throw a second request at cycle dis_at.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int dis_at, input logic [2:0] dop, input logic [31:0] da);
        logic [63:0] exp;
        int cyc;
        logic got, busy_ok;
        exp = model(o, a, b);
        @(negedge clk);
        op = o; srcA = a; srcB = b; start = 1'b1;
        cyc = 0; got = 1'b0; busy_ok = 1'b1;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == dis_at) begin
                op = dop; srcA = da; srcB = ~da; start = 1'b1;
            end
            if (done) got = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        check("done_seen", got, 1);
        check("latency", cyc, 34);
        check("busy_until_done", busy_ok, 1);
        check("busy_low_in_done", busy, 0);
        check("hi", hi, exp[63:32]);
        check("lo", lo, exp[31:0]);
        check("zero", zero, exp == 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        model_hi = exp[63:32];
        model_lo = exp[31:0];
    endtask

    task automatic move_to(input logic [2:0] o, input logic [31:0] v);
        @(negedge clk);
        op = o; srcA = v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (o == MTHI) model_hi = v; else model_lo = v;
        check("mt_busy", busy, 0);
        check("mt_done", done, 0);
        check("mt_hi", hi, model_hi);
        check("mt_lo", lo, model_lo);
    endtask

    task automatic run8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_hi, input logic [7:0] exp_lo);
        int cyc;
        @(negedge clk);
        op8 = o; srcA8 = a; srcB8 = b; start8 = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start8 = 1'b0;
        end while (!done8 && cyc < 100);
        check("w8_latency", cyc, 10);
        check("w8_hi", hi8, exp_hi);
        check("w8_lo", lo8, exp_lo);
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        logic        seen;
        int          sel;

        // Reset state.
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_zero", zero, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run_op(MULTU, 32'hFFFF_FFFF, 32'h2, 0, 0, 0);
        run_op(MULT, -32'sd3, 32'sd7, 0, 0, 0);
        run_op(DIV, -32'sd7, 32'sd2, 0, 0, 0);
        run_op(DIVU, 32'd100, 32'd0, 0, 0, 0);
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        run_op(DIV, 32'hFFFF_FFF0, 32'd0, 0, 0, 0);

        // Requests while busy are dropped.
        run_op(MULTU, 32'd12345, 32'd678, 5, MULT, 32'h5555_0001);
        run_op(DIVU, 32'd99999, 32'd37, 7, MTLO, 32'h1234);

        // Abort on cycle 10 of a divide.
        @(negedge clk);
        op = DIVU; srcA = 32'd1000; srcB = 32'd7; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort_busy_before", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi, model_hi);
        check("abort_lo", lo, model_lo);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("abort_stays_idle", seen, 0);

        // Abort wins over a start in idle, including MTHI.
        @(negedge clk);
        op = MTHI; srcA = 32'hABCD; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        op = MULTU; srcA = 32'd3; srcB = 32'd3;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_hi", hi, model_hi);

        // MTHI/MTLO, then zero flag.
        move_to(MTHI, 32'hDEAD_BEEF);
        move_to(MTLO, 32'h0BAD_F00D);
        move_to(MTHI, 32'h0);
        move_to(MTLO, 32'h0);
        check("mt_zero", zero, 1);

        // Randomized operations against the model.
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'h0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = $urandom_range(1, 15);
            if (sel == 3) a = a >> 20;
            run_op(o, a, b, 0, 0, 0);
        end

        // Narrow instance.
        run8(MULTU, 8'hFF, 8'h02, 8'h01, 8'hFE);
        run8(DIV, 8'hF9, 8'h02, 8'hFF, 8'hFD);

        // Reset in the middle of a multiply.
        @(negedge clk);
        op = MULT; srcA = 32'h7FFF_0001; srcB = 32'h0000_0303; start = 1'b1;
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_hi", hi, 0);
        check("mid_rst_lo", lo, 0);
        check("mid_rst_zero", zero, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("mid_rst_no_done", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
